// File: rtl/counter_if.sv
// Control/status bundle for the up/down counter: the master drives the controls and the
// slave (the counter) returns the registered count and the terminal-count flag.
interface counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up_dn;
    logic [WIDTH-1:0] count;
    logic             tc;

    modport master (
        output en, load, load_val, up_dn,
        input  count, tc
    );

    modport slave (
        input  en, load, load_val, up_dn,
        output count, tc
    );
endinterface

// File: rtl/counter.sv
// Parameterised up/down counter with enable, clamped parallel load and terminal-count flag.
// Define COUNTER_SATURATE_EN to make the count saturate at 0/MAX_VAL instead of wrapping.
module counter #(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 64'd1
) (
    input logic      clk,
    input logic      rst,
    counter_if.slave bus
);

`ifdef COUNTER_SATURATE_EN
    localparam bit Saturate = 1'b1;
`else
    localparam bit Saturate = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max, at_zero;

    assign at_max       = (count_q == MaxCount);
    assign at_zero      = (count_q == '0);
    assign load_clamped = (bus.load_val > MaxCount) ? MaxCount : bus.load_val;

    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = load_clamped;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_max) count_d = Saturate ? MaxCount : '0;
                else        count_d = count_q + WIDTH'(1);
            end else begin
                if (at_zero) count_d = Saturate ? '0 : MaxCount;
                else         count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign bus.count = count_q;
    // Gated by rst so the flag is low for the whole reset, not just once count reads 0.
    assign bus.tc    = ~rst & bus.en & ~bus.load &
                       ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: a default 4-bit instance (a) and a MAX_VAL=9 instance (b)
// driven from a vector table, with expected counts queued at drive time and popped after the edge.
module tb_counter;

`ifdef COUNTER_SATURATE_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif

    logic clk;
    logic rst;

    counter_if #(.WIDTH(4)) bus_a ();
    counter_if #(.WIDTH(4)) bus_b ();

    counter #(.WIDTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    counter #(.WIDTH(4), .MAX_VAL(9)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        bit         sel;
        bit         load;
        bit         en;
        bit         up_dn;
        logic [3:0] load_val;
        bit         exp_tc;
        logic [3:0] exp_count;
    } vec_t;

    typedef struct {
        bit         sel;
        logic [3:0] exp_count;
        string      name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void add(input bit sel, input bit load, input bit en, input bit up_dn,
                                input logic [3:0] lv, input bit exp_tc, input logic [3:0] exp_c);
        vec_t v;
        v.sel = sel; v.load = load; v.en = en; v.up_dn = up_dn; v.load_val = lv;
        v.exp_tc = exp_tc; v.exp_count = exp_c;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        if (!v.sel) begin
            bus_a.load = v.load; bus_a.en = v.en; bus_a.up_dn = v.up_dn; bus_a.load_val = v.load_val;
        end else begin
            bus_b.load = v.load; bus_b.en = v.en; bus_b.up_dn = v.up_dn; bus_b.load_val = v.load_val;
        end
    endtask

    // Drive at negedge, check tc before the edge, check count just after it.
    task automatic step(input vec_t v, input string name);
        sb_t e;
        @(negedge clk);
        drive(v);
        #1;
        check({name, "_tc"}, v.sel ? int'(bus_b.tc) : int'(bus_a.tc), int'(v.exp_tc));
        e.sel = v.sel; e.exp_count = v.exp_count; e.name = {name, "_count"};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.name, e.sel ? int'(bus_b.count) : int'(bus_a.count), int'(e.exp_count));
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        // Inputs that would count and raise tc if reset were not dominant.
        bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up_dn = 1'b0; bus_a.load_val = 4'd5;
        bus_b.load = 1'b1; bus_b.en = 1'b1; bus_b.up_dn = 1'b1; bus_b.load_val = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        check("reset_a_count", int'(bus_a.count), 0);
        check("reset_a_tc", int'(bus_a.tc), 0);
        check("reset_b_count", int'(bus_b.count), 0);
        bus_a.en = 1'b0; bus_a.up_dn = 1'b1;
        bus_b.load = 1'b0; bus_b.en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Idle cycle, count 8, hold 2, count 5 more.
        add(0, 0, 0, 1, 4'd0, 0, 4'd0);
        for (int i = 1; i <= 8; i++) add(0, 0, 1, 1, 4'd0, 0, 4'(i));
        repeat (2) add(0, 0, 0, 1, 4'd0, 0, 4'd8);
        for (int i = 9; i <= 13; i++) add(0, 0, 1, 1, 4'd0, 0, 4'(i));
        // Full 16-edge run from 0 with the wrap (or saturation) at 15.
        add(0, 1, 1, 1, 4'd0, 0, 4'd0);
        for (int i = 1; i <= 15; i++) add(0, 0, 1, 1, 4'd0, 0, 4'(i));
        add(0, 0, 1, 1, 4'd0, 1, Sat ? 4'd15 : 4'd0);
        if (Sat) add(0, 0, 1, 1, 4'd0, 1, 4'd15);
        add(0, 0, 0, 1, 4'd0, 0, Sat ? 4'd15 : 4'd0);
        // Load 9 with en low, then count down through 0.
        add(0, 1, 0, 1, 4'd9, 0, 4'd9);
        for (int i = 8; i >= 0; i--) add(0, 0, 1, 0, 4'd0, 0, 4'(i));
        add(0, 0, 1, 0, 4'd0, 1, Sat ? 4'd0 : 4'd15);
        add(0, 0, 1, 0, 4'd0, Sat, Sat ? 4'd0 : 4'd14);
        // Load beats enable; tc is gated by en.
        add(0, 1, 0, 1, 4'd10, 0, 4'd10);
        add(0, 1, 1, 1, 4'd3, 0, 4'd3);
        add(0, 1, 0, 0, 4'd0, 0, 4'd0);
        add(0, 0, 0, 0, 4'd0, 0, 4'd0);
        // Direction change at the top.
        add(0, 1, 1, 1, 4'd15, 0, 4'd15);
        add(0, 0, 1, 0, 4'd0, 0, 4'd14);
        add(0, 0, 1, 1, 4'd0, 0, 4'd15);
        add(0, 0, 0, 1, 4'd0, 0, 4'd15);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("a_vec%0d", i));
        vecs.delete();

        // Asynchronous reset between edges while count is 7.
        v = '{sel: 0, load: 1, en: 0, up_dn: 1, load_val: 4'd7, exp_tc: 0, exp_count: 4'd7};
        step(v, "a_load7");
        @(negedge clk);
        bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up_dn = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count", int'(bus_a.count), 0);
        check("async_rst_tc", int'(bus_a.tc), 0);
        bus_a.en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        v = '{sel: 0, load: 0, en: 1, up_dn: 1, load_val: 4'd0, exp_tc: 0, exp_count: 4'd1};
        step(v, "a_after_rst");
        v = '{sel: 0, load: 0, en: 0, up_dn: 1, load_val: 4'd0, exp_tc: 0, exp_count: 4'd1};
        step(v, "a_idle");

        // MAX_VAL=9 instance: modulus-10 sequence, load clamping, down wrap.
        for (int i = 1; i <= 9; i++) add(1, 0, 1, 1, 4'd0, 0, 4'(i));
        add(1, 0, 1, 1, 4'd0, 1, Sat ? 4'd9 : 4'd0);
        add(1, 1, 0, 1, 4'd12, 0, 4'd9);
        add(1, 1, 1, 0, 4'd15, 0, 4'd9);
        add(1, 0, 1, 0, 4'd0, 0, 4'd8);
        add(1, 1, 0, 0, 4'd0, 0, 4'd0);
        add(1, 0, 1, 0, 4'd0, 1, Sat ? 4'd0 : 4'd9);
        add(1, 1, 0, 1, 4'd8, 0, 4'd8);
        add(1, 0, 1, 1, 4'd0, 0, 4'd9);
        add(1, 0, 0, 1, 4'd0, 0, 4'd9);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("b_vec%0d", i));

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Parameterised synchronous up/down counter with clock enable, parallel load and terminal-count flag.
- General-purpose event/cycle counter for control logic. The default configuration is a free-running 4-bit up counter gated by en.
- Single clock domain with an asynchronous active-high reset.

Parameters:
- WIDTH, 4, bit width of count and load_val; legal range 1..32.
- MAX_VAL, 2**WIDTH-1, terminal value; the count sequence is 0..MAX_VAL (modulus MAX_VAL+1); must be >=1 and <=2**WIDTH-1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous active-high reset; assertion clears state immediately; deassertion is synchronised externally.
- en  input  1  count enable; when low (and load low) count holds.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count flag, combinational from count/en/up_dn.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst). Both are fixed.
- Reset: while rst=1, count=0 and tc=0, regardless of clk or other inputs. This includes reset asserted mid-count.
- First update after reset release is at the first rising clk edge with rst=0.
- Per rising edge, priority rst > load > en > hold.
- load=1: count <= min(load_val, MAX_VAL). Load ignores en and up_dn.
- load=0, en=1, up_dn=1:
  - count < MAX_VAL -> count+1.
  - count == MAX_VAL -> 0 (wrap).
- load=0, en=1, up_dn=0:
  - count > 0 -> count-1.
  - count == 0 -> MAX_VAL (wrap).
- load=0, en=0: count holds its value indefinitely.
- Latency: one cycle. count reflects the edge at which en/load was sampled. No combinational path from en to count.
- tc = en & ~load & ((up_dn & count==MAX_VAL) | (~up_dn & count==0)).
  - tc is high in the cycle before a wrap. It marks exactly one cycle per full sequence when en stays high.
- up_dn may change on any cycle; the new direction takes effect at the next enabled edge.
- All arithmetic is modulo MAX_VAL+1. No X propagation from load_val when load=0.
- en toggling mid-sequence resumes from the held value. The count never resets on en deassertion.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined:
  - Up count at MAX_VAL holds at MAX_VAL; down count at 0 holds at 0. No wrap.
  - tc still asserts under the same conditions and stays high while saturated and enabled.
  - Load behaviour is unchanged.
- Undefined: wrap-around behaviour as specified above (default build).

Test Plan:
- Reset release, en=0 for 1 cycle, then en=1, up_dn=1 for 8 edges -> count 0,1,2,...,8. Then en=0 for 2 edges -> count holds 8. Then en=1 for 5 edges -> count 13.
- Default WIDTH=4, en=1, up_dn=1 from 0 for 16 edges:
  - count reaches 15 with tc=1, then wraps to 0 with tc=0.
  - With COUNTER_SATURATE_EN: count stays 15, tc=1.
- load=1, load_val=9 with en=0 -> count=9 next edge. Then up_dn=0, en=1 for 10 edges -> 8..0, then 15 (wrap). tc=1 exactly when count=0.
- MAX_VAL=9, up counting -> sequence 0..9,0. Then load_val=12 -> count=9 (clamped).
- rst asserted asynchronously between edges while count=7 -> count=0 immediately without a clock edge. After release, counting resumes from 0.
- load=1 and en=1 in the same cycle with load_val=3, count=10 -> count=3 (load wins).
